// File: rtl/uart_pkg.sv
// uart_pkg: state encoding and parity selectors shared by the UART TX and RX paths
package uart_pkg;
    typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP} tx_state_e;
    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;
endpackage

// File: rtl/uart_tx_serializer.sv
// tx_serializer: loadable right-shift payload register with bit index and last-bit flag
module tx_serializer
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  load,
    input  logic                  shift,
    input  logic [DATA_WIDTH-1:0] data,
    output logic                  cur_bit,
    output logic                  nxt_bit,
    output logic                  last_bit
);
    localparam int IW = DATA_WIDTH > 1 ? $clog2(DATA_WIDTH) : 1;
    logic [DATA_WIDTH-1:0] sreg;
    logic [IW-1:0]         idx;
    always_ff @(posedge i_clk or negedge i_reset)
        if (!i_reset) begin
            sreg <= '0;
            idx  <= '0;
        end else if (load) begin
            sreg <= data;
            idx  <= '0;
        end else if (shift) begin
            sreg <= sreg >> 1;
            idx  <= idx + 1'b1;
        end
    assign cur_bit  = sreg[0];
    assign nxt_bit  = sreg[1];
    assign last_bit = idx == IW'(DATA_WIDTH - 1);
endmodule

// File: rtl/uart_tx.sv
// uart_tx: framed serial transmitter (start, LSB-first data, optional parity, stop) with valid/busy handshake
module uart_tx
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH   = 8,
    parameter int CLKS_PER_BIT = 8
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic [DATA_WIDTH-1:0] i_p_data,
    input  logic                  i_data_valid,
    input  logic                  i_par_en,
    input  logic                  i_par_typ,
    output logic                  o_tx_out,
    output logic                  o_busy,
    output logic                  o_tx_done
);
    localparam int TW = CLKS_PER_BIT > 1 ? $clog2(CLKS_PER_BIT) : 1;
    generate
        if (CLKS_PER_BIT < 1) begin : g_bad_cpb
            $error("uart_tx: CLKS_PER_BIT must be >= 1");
        end
    endgenerate
    tx_state_e     state, state_nx;
    logic [TW-1:0] timer, timer_nx;
    logic          par_en_q, par_bit_q, tc, accept, shift, line_nx;
    logic          cur_bit, nxt_bit, last_bit;
    assign tc     = timer == TW'(CLKS_PER_BIT - 1);
    assign accept = state == TX_IDLE && i_data_valid && !o_busy;
    assign shift  = state == TX_DATA && tc;
    tx_serializer #(.DATA_WIDTH(DATA_WIDTH)) u_ser (
        .i_clk    (i_clk),
        .i_reset  (i_reset),
        .load     (accept),
        .shift    (shift),
        .data     (i_p_data),
        .cur_bit  (cur_bit),
        .nxt_bit  (nxt_bit),
        .last_bit (last_bit)
    );
    always_comb begin
        state_nx = state;
        case (state)
            TX_IDLE:   state_nx = accept ? TX_START : TX_IDLE;
            TX_START:  state_nx = tc ? TX_DATA : TX_START;
            TX_DATA:   state_nx = (tc && last_bit) ? (par_en_q ? TX_PARITY : TX_STOP) : TX_DATA;
            TX_PARITY: state_nx = tc ? TX_STOP : TX_PARITY;
            TX_STOP:   state_nx = tc ? TX_IDLE : TX_STOP;
            default:   state_nx = TX_IDLE;
        endcase
        timer_nx = (state == TX_IDLE || tc) ? '0 : timer + 1'b1;
        // Outputs are registered from the next state so the line moves on the same edge as the FSM.
        line_nx  = state_nx == TX_START  ? 1'b0 :
                   state_nx == TX_DATA   ? (shift ? nxt_bit : cur_bit) :
                   state_nx == TX_PARITY ? par_bit_q : 1'b1;
    end
    always_ff @(posedge i_clk or negedge i_reset)
        if (!i_reset) begin
            state     <= TX_IDLE;
            timer     <= '0;
            par_en_q  <= 1'b0;
            par_bit_q <= 1'b0;
            o_tx_out  <= 1'b1;
            o_busy    <= 1'b0;
            o_tx_done <= 1'b0;
        end else begin
            state     <= state_nx;
            timer     <= timer_nx;
            o_tx_out  <= line_nx;
            o_busy    <= state_nx != TX_IDLE;
            o_tx_done <= state_nx == TX_STOP && timer_nx == TW'(CLKS_PER_BIT - 1);
            if (accept) begin
                par_en_q  <= i_par_en;
                par_bit_q <= (^i_p_data) ^ (i_par_typ == PAR_ODD);
            end
        end
endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: scoreboard bench for uart_tx at CLKS_PER_BIT=4 and CLKS_PER_BIT=1
module tb_uart_tx;
    import uart_pkg::*;
    localparam int CPB = 4;
    logic clk = 1'b0, rst_n = 1'b0;
    always #5 clk = ~clk;
    logic [7:0] data_a = '0, data_b = '0;
    logic valid_a = 0, pe_a = 0, pt_a = 0, tx_a, busy_a, done_a;
    logic valid_b = 0, pe_b = 0, pt_b = 0, tx_b, busy_b, done_b;
    uart_tx #(.DATA_WIDTH(8), .CLKS_PER_BIT(CPB)) dut (
        .i_clk(clk), .i_reset(rst_n), .i_p_data(data_a), .i_data_valid(valid_a),
        .i_par_en(pe_a), .i_par_typ(pt_a), .o_tx_out(tx_a), .o_busy(busy_a), .o_tx_done(done_a));
    uart_tx #(.DATA_WIDTH(8), .CLKS_PER_BIT(1)) dut_b (
        .i_clk(clk), .i_reset(rst_n), .i_p_data(data_b), .i_data_valid(valid_b),
        .i_par_en(pe_b), .i_par_typ(pt_b), .o_tx_out(tx_b), .o_busy(busy_b), .o_tx_done(done_b));

    typedef struct packed {logic [7:0] d; logic pe; logic pt;} frame_t;
    frame_t     exp_q[$];
    logic [7:0] rx_q[$];
    int         start_cyc[$];
    int vectors = 0, miscompares = 0, starts = 0, frames_ok = 0, done_cnt = 0, cyc = 0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (done_a) done_cnt <= done_cnt + 1;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [10:0] frame_bits(input frame_t f);
        return f.pe ? {1'b1, (^f.d) ^ f.pt, f.d, 1'b0} : {2'b11, f.d, 1'b0};
    endfunction

    function automatic logic [63:0] expand(input logic [10:0] bits, input int nb, input int cpb);
        logic [63:0] v = '0;
        for (int i = 0; i < nb * cpb; i++) v[i] = bits[i / cpb];
        return v;
    endfunction

    // Monitor: pops one expectation per start edge and checks the whole frame cycle by cycle.
    frame_t      mf;
    int          mlen;
    logic [63:0] line_v, busy_v, done_v;
    logic        abort;
    initial forever begin
        @(negedge clk);
        if (rst_n && tx_a === 1'b0) begin
            starts++;
            start_cyc.push_back(cyc);
            if (exp_q.size() == 0) begin
                check("unexpected_frame", 1, 0);
                while (busy_a === 1'b1) @(negedge clk);
            end else begin
                mf = exp_q.pop_front();
                mlen = (mf.pe ? 11 : 10) * CPB;
                abort = 0; line_v = '0; busy_v = '0; done_v = '0;
                for (int i = 0; i < mlen; i++) begin
                    if (i > 0) @(negedge clk);
                    if (!rst_n) begin
                        abort = 1;
                        break;
                    end
                    line_v[i] = tx_a; busy_v[i] = busy_a; done_v[i] = done_a;
                end
                if (!abort) begin
                    check("line", line_v, expand(frame_bits(mf), mf.pe ? 11 : 10, CPB));
                    check("busy", busy_v, (64'd1 << mlen) - 64'd1);
                    check("done", done_v, 64'd1 << (mlen - 1));
                    @(negedge clk);
                    check("idle_after", {busy_a, tx_a}, 2'b01);
                    frames_ok++;
                end
            end
        end
    end

    task automatic wait_idle_a();
        int n = 0;
        while (busy_a !== 1'b0 && n < 400) begin
            @(negedge clk);
            n++;
        end
        check("idle_wait", n < 400, 1);
    endtask

    task automatic send_a(input logic [7:0] d, input logic pe, input logic pt);
        wait_idle_a();
        data_a = d; pe_a = pe; pt_a = pt; valid_a = 1;
        exp_q.push_back(frame_t'{d, pe, pt});
        @(negedge clk);
        valid_a = 0;
        check("accept_lat", {busy_a, tx_a}, 2'b10);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int s0, n, d0;
        logic [63:0] lb, db;
        logic [7:0]  rx;
        repeat (3) @(negedge clk);
        check("rst_a", {tx_a, busy_a, done_a}, 3'b100);
        check("rst_b", {tx_b, busy_b, done_b}, 3'b100);
        rst_n = 1;
        @(negedge clk);
        send_a(8'hA5, 0, PAR_EVEN);
        send_a(8'hA5, 1, PAR_EVEN);
        send_a(8'hA5, 1, PAR_ODD);
        send_a(8'h07, 1, PAR_EVEN);
        repeat (10) @(negedge clk);
        data_a = 8'hFF; pt_a = PAR_ODD; pe_a = 0;
        send_a(8'h11, 0, PAR_EVEN);
        repeat (5) @(negedge clk);
        data_a = 8'h3C; valid_a = 1;
        @(negedge clk);
        valid_a = 0;
        send_a(8'h22, 0, PAR_EVEN);
        wait_idle_a();
        s0 = starts;
        exp_q.push_back(frame_t'{8'h5A, 1'b0, 1'b0});
        exp_q.push_back(frame_t'{8'h5A, 1'b0, 1'b0});
        data_a = 8'h5A; pe_a = 0; valid_a = 1;
        n = 0;
        while (starts < s0 + 2 && n < 300) begin
            @(negedge clk);
            n++;
        end
        valid_a = 0;
        check("held_two_starts", starts >= s0 + 2, 1);
        if (start_cyc.size() >= s0 + 2)
            check("held_gap", start_cyc[s0 + 1] - start_cyc[s0], 41);
        send_a(8'hC3, 0, PAR_EVEN);
        repeat (17) @(negedge clk);
        @(posedge clk);
        #1;
        d0 = done_cnt;
        rst_n = 0;
        #1;
        check("rst_async", {tx_a, busy_a, done_a}, 3'b100);
        repeat (2) @(negedge clk);
        rst_n = 1;
        check("no_done_abort", done_cnt, d0);
        send_a(8'h81, 0, PAR_EVEN);
        rx_q.push_back(8'hFF);
        data_b = 8'hFF; pe_b = 1; pt_b = PAR_ODD; valid_b = 1;
        @(negedge clk);
        valid_b = 0;
        lb = '0; db = '0;
        for (int i = 0; i < 11; i++) begin
            lb[i] = tx_b; db[i] = done_b;
            @(negedge clk);
        end
        check("cpb1_line", lb, expand(frame_bits(frame_t'{8'hFF, 1'b1, PAR_ODD}), 11, 1));
        check("cpb1_done", db, 64'd1 << 10);
        check("cpb1_idle", {busy_b, tx_b}, 2'b01);
        rx = lb[8:1];
        check("rx_start", lb[0], 0);
        check("rx_parity_odd", (^rx) ^ lb[9], 1);
        check("rx_stop", lb[10], 1);
        check("rx_byte", rx, rx_q.pop_front());
        n = 0;
        while (frames_ok < 9 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check("frames_done", frames_ok, 9);
        check("drain", exp_q.size(), 0);
        check("done_count", done_cnt, 9);
        if (start_cyc.size() >= 6)
            check("gap_after_ignored", start_cyc[5] - start_cyc[4] >= 41, 1);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
